// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants and the CDB lane-packing helper used by
// every producer and consumer of the flat broadcast buses.
package ooo_pkg;

   localparam int ROB_IDX_W     = 4;
   localparam int DATA_W        = 16;
   localparam int NUM_CDB_LANES = 4;

   // Lane 0 lives in the most significant flat slot.
   function automatic logic [1:0] lane_slot(input logic [1:0] lane);
      return 2'd3 - lane;
   endfunction

endpackage

// File: rtl/rr_multi_pick.sv
// Combinational round-robin picker: grants up to four requesters in scan order
// starting at start_i and reports which requester feeds each lane.
module rr_multi_pick
   import ooo_pkg::*;
#(
   parameter int N  = 6,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]                      req_i,
   input  logic [PW-1:0]                     start_i,
   output logic [N-1:0]                      grant_o,
   output logic [NUM_CDB_LANES-1:0][PW-1:0]  lane_sel_o,
   output logic [NUM_CDB_LANES-1:0]          lane_vld_o,
   output logic [PW-1:0]                     last_o,
   output logic                              any_o
);

   logic [PW:0]   sum_s;
   logic [PW-1:0] pick_s;
   logic [2:0]    cnt_s;

   // Walk the requesters from start_i with wrap-around, filling lanes in order.
   always_comb begin
      grant_o    = '0;
      lane_sel_o = '0;
      lane_vld_o = '0;
      last_o     = '0;
      cnt_s      = 3'd0;
      sum_s      = '0;
      pick_s     = '0;
      for (int s = 0; s < N; s++) begin
         sum_s = {1'b0, start_i} + (PW+1)'(s);
         if (sum_s >= (PW+1)'(N)) begin
            sum_s = sum_s - (PW+1)'(N);
         end else begin
            sum_s = sum_s;
         end
         pick_s = sum_s[PW-1:0];
         if (req_i[pick_s] && (cnt_s < 3'd4)) begin
            grant_o[pick_s]          = 1'b1;
            lane_sel_o[cnt_s[1:0]]   = pick_s;
            lane_vld_o[cnt_s[1:0]]   = 1'b1;
            last_o                   = pick_s;
            cnt_s                    = cnt_s + 3'd1;
         end else begin
            cnt_s = cnt_s;
         end
      end
      any_o = (cnt_s != 3'd0);
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding register per functional unit, up to four
// round-robin grants per cycle, registered flat CDB lanes.
module cdb_arbiter
   import ooo_pkg::*;
#(
   parameter int NUM_FU = 6
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 flush,
   input  logic [NUM_FU-1:0]                    fu_valid_flat,
   input  logic [ROB_IDX_W*NUM_FU-1:0]          fu_rob_index_flat,
   input  logic [DATA_W*NUM_FU-1:0]             fu_result_flat,
   output logic [NUM_FU-1:0]                    fu_ready_flat,
   output logic [NUM_CDB_LANES-1:0]             cdb_valid_flat,
   output logic [ROB_IDX_W*NUM_CDB_LANES-1:0]   cdb_rob_index_flat,
   output logic [DATA_W*NUM_CDB_LANES-1:0]      cdb_result_flat,
   output logic                                 busy
);

   localparam int PW = $clog2(NUM_FU);

   logic [NUM_FU-1:0]                   hold_valid_q, hold_valid_d;
   logic [NUM_FU-1:0][ROB_IDX_W-1:0]    hold_idx_q,   hold_idx_d;
   logic [NUM_FU-1:0][DATA_W-1:0]       hold_data_q,  hold_data_d;
   logic [PW-1:0]                       rr_ptr_q,     rr_ptr_d;
   logic [NUM_CDB_LANES-1:0]            cdb_valid_q,  cdb_valid_d;
   logic [ROB_IDX_W*NUM_CDB_LANES-1:0]  cdb_idx_q,    cdb_idx_d;
   logic [DATA_W*NUM_CDB_LANES-1:0]     cdb_data_q,   cdb_data_d;

   logic [NUM_FU-1:0]                      grant_s;
   logic [NUM_CDB_LANES-1:0][PW-1:0]       lane_sel_s;
   logic [NUM_CDB_LANES-1:0]               lane_vld_s;
   logic [PW-1:0]                          last_s;
   logic                                   any_s;

   rr_multi_pick #(
      .N  (NUM_FU),
      .PW (PW)
   ) u_pick (
      .req_i      (hold_valid_q),
      .start_i    (rr_ptr_q),
      .grant_o    (grant_s),
      .lane_sel_o (lane_sel_s),
      .lane_vld_o (lane_vld_s),
      .last_o     (last_s),
      .any_o      (any_s)
   );

   // A holder being drained this edge can take a new result in the same edge.
   assign fu_ready_flat      = ~hold_valid_q | grant_s;
   assign busy               = |hold_valid_q;
   assign cdb_valid_flat     = cdb_valid_q;
   assign cdb_rob_index_flat = cdb_idx_q;
   assign cdb_result_flat    = cdb_data_q;

   // Next state: drain granted holders onto the lanes, accept new results, advance pointer.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_idx_d   = hold_idx_q;
      hold_data_d  = hold_data_q;
      rr_ptr_d     = rr_ptr_q;
      cdb_valid_d  = '0;
      cdb_idx_d    = cdb_idx_q;
      cdb_data_d   = cdb_data_q;
      if (flush) begin
         hold_valid_d = '0;
      end else begin
         for (int f = 0; f < NUM_FU; f++) begin
            if (fu_valid_flat[f] && fu_ready_flat[f]) begin
               hold_valid_d[f] = 1'b1;
               hold_idx_d[f]   = fu_rob_index_flat[ROB_IDX_W*f +: ROB_IDX_W];
               hold_data_d[f]  = fu_result_flat[DATA_W*f +: DATA_W];
            end else begin
               hold_valid_d[f] = hold_valid_q[f] & ~grant_s[f];
            end
         end
         for (int k = 0; k < NUM_CDB_LANES; k++) begin
            if (lane_vld_s[k]) begin
               cdb_valid_d[lane_slot(2'(k))] = 1'b1;
               cdb_idx_d[ROB_IDX_W*lane_slot(2'(k)) +: ROB_IDX_W] = hold_idx_q[lane_sel_s[k]];
               cdb_data_d[DATA_W*lane_slot(2'(k)) +: DATA_W]      = hold_data_q[lane_sel_s[k]];
            end else begin
               cdb_valid_d[lane_slot(2'(k))] = 1'b0;
            end
         end
         if (any_s) begin
            if (last_s == PW'(NUM_FU-1)) begin
               rr_ptr_d = '0;
            end else begin
               rr_ptr_d = last_s + PW'(1);
            end
         end else begin
            rr_ptr_d = rr_ptr_q;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid_q <= '0;
         hold_idx_q   <= '0;
         hold_data_q  <= '0;
         rr_ptr_q     <= '0;
         cdb_valid_q  <= '0;
         cdb_idx_q    <= '0;
         cdb_data_q   <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_idx_q   <= hold_idx_d;
         hold_data_q  <= hold_data_d;
         rr_ptr_q     <= rr_ptr_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_idx_q    <= cdb_idx_d;
         cdb_data_q   <= cdb_data_d;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_cdb_arbiter;

   localparam int N = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic [N-1:0]    fu_valid_flat;
   logic [4*N-1:0]  fu_rob_index_flat;
   logic [16*N-1:0] fu_result_flat;
   logic [N-1:0]    fu_ready_flat;
   logic [3:0]      cdb_valid_flat;
   logic [15:0]     cdb_rob_index_flat;
   logic [63:0]     cdb_result_flat;
   logic            busy;

   always #5 clk = ~clk;

   cdb_arbiter #(.NUM_FU(N)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .flush              (flush),
      .fu_valid_flat      (fu_valid_flat),
      .fu_rob_index_flat  (fu_rob_index_flat),
      .fu_result_flat     (fu_result_flat),
      .fu_ready_flat      (fu_ready_flat),
      .cdb_valid_flat     (cdb_valid_flat),
      .cdb_rob_index_flat (cdb_rob_index_flat),
      .cdb_result_flat    (cdb_result_flat),
      .busy               (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: holders, pointer and CDB registers.
   logic [N-1:0] m_hv;
   logic [3:0]   m_hi [N];
   logic [15:0]  m_hd [N];
   int           m_ptr;
   logic [3:0]   m_cv;
   logic [15:0]  m_ci;
   logic [63:0]  m_cd;

   typedef int iq_t[$];

   function automatic iq_t granted_fus();
      iq_t q;
      for (int s = 0; s < N; s++) begin
         int f = (m_ptr + s) % N;
         if (m_hv[f] && q.size() < 4) q.push_back(f);
      end
      return q;
   endfunction

   function automatic logic [N-1:0] exp_ready();
      iq_t q = granted_fus();
      logic [N-1:0] r = ~m_hv;
      foreach (q[i]) r[q[i]] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      iq_t          q;
      logic [N-1:0] rdy;
      logic [N-1:0] hv;
      logic [3:0]   cv;
      logic [15:0]  ci;
      logic [63:0]  cd;
      if (!rst_n) begin
         m_hv  <= '0;
         m_ptr <= 0;
         m_cv  <= 4'd0;
         m_ci  <= 16'd0;
         m_cd  <= 64'd0;
         for (int f = 0; f < N; f++) begin
            m_hi[f] <= 4'd0;
            m_hd[f] <= 16'd0;
         end
      end else if (flush) begin
         m_hv <= '0;
         m_cv <= 4'd0;
      end else begin
         q   = granted_fus();
         rdy = exp_ready();
         hv  = m_hv;
         cv  = 4'd0;
         ci  = m_ci;
         cd  = m_cd;
         foreach (q[k]) begin
            cv[3-k]             = 1'b1;
            ci[4*(3-k) +: 4]    = m_hi[q[k]];
            cd[16*(3-k) +: 16]  = m_hd[q[k]];
            hv[q[k]]            = 1'b0;
         end
         for (int f = 0; f < N; f++) begin
            if (fu_valid_flat[f] && rdy[f]) begin
               hv[f]   = 1'b1;
               m_hi[f] <= fu_rob_index_flat[4*f +: 4];
               m_hd[f] <= fu_result_flat[16*f +: 16];
            end
         end
         if (q.size() > 0) m_ptr <= (q[q.size()-1] + 1) % N;
         m_hv <= hv;
         m_cv <= cv;
         m_ci <= ci;
         m_cd <= cd;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_ready",  fu_ready_flat,      exp_ready());
         check("m_busy",   busy,               |m_hv);
         check("m_valid",  cdb_valid_flat,     m_cv);
         check("m_index",  cdb_rob_index_flat, m_ci);
         check("m_result", cdb_result_flat,    m_cd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fu_valid_flat = '0;
      flush         = 1'b0;
   endtask

   task automatic set_fu(input int f, input logic [3:0] idx, input logic [15:0] d);
      fu_valid_flat[f]             = 1'b1;
      fu_rob_index_flat[4*f +: 4]  = idx;
      fu_result_flat[16*f +: 16]   = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n             = 1'b1;
      flush             = 1'b0;
      fu_valid_flat     = '0;
      fu_rob_index_flat = '0;
      fu_result_flat    = '0;
      #2;
      do_reset();
      chk_en = 1'b1;

      // Reset state and a single result.
      check("rst_valid",  cdb_valid_flat,     4'd0);
      check("rst_index",  cdb_rob_index_flat, 16'd0);
      check("rst_result", cdb_result_flat,    64'd0);
      check("rst_ready",  fu_ready_flat,      6'h3F);
      check("rst_busy",   busy,               1'b0);
      set_fu(2, 4'd5, 16'h1234);
      check("single_ready2", fu_ready_flat[2], 1'b1);
      tick();
      idle();
      check("single_busy", busy, 1'b1);
      tick();
      check("single_valid",  cdb_valid_flat,     4'b1000);
      check("single_index",  cdb_rob_index_flat, 16'h5000);
      check("single_result", cdb_result_flat,    64'h1234_0000_0000_0000);
      tick();
      check("single_gone", cdb_valid_flat, 4'b0000);

      // Four at once, then probe that the pointer moved to 4.
      do_reset();
      for (int f = 0; f < 4; f++) set_fu(f, 4'(f + 1), 16'hA001 + 16'(f));
      tick();
      idle();
      tick();
      check("four_valid",  cdb_valid_flat,     4'b1111);
      check("four_index",  cdb_rob_index_flat, 16'h1234);
      check("four_result", cdb_result_flat,    64'hA001_A002_A003_A004);
      set_fu(0, 4'd6, 16'hA006);
      set_fu(4, 4'd7, 16'hA007);
      tick();
      idle();
      tick();
      check("ptr4_valid", cdb_valid_flat,     4'b1100);
      check("ptr4_index", cdb_rob_index_flat, 16'h7634);

      // Six-way contention.
      do_reset();
      for (int f = 0; f < N; f++) set_fu(f, 4'(f), 16'h6000 + 16'(f));
      tick();
      for (int f = 0; f < 4; f++) set_fu(f, 4'(f + 6), 16'h6006 + 16'(f));
      set_fu(4, 4'd10, 16'h600A);
      set_fu(5, 4'd11, 16'h600B);
      check("six_readyA", fu_ready_flat, 6'b001111);
      tick();
      check("six_A_valid",  cdb_valid_flat,     4'b1111);
      check("six_A_index",  cdb_rob_index_flat, 16'h0123);
      check("six_A_result", cdb_result_flat,    64'h6000_6001_6002_6003);
      fu_valid_flat[3:0] = 4'b0000;
      check("six_readyB", fu_ready_flat, 6'b110011);
      tick();
      idle();
      check("six_B_valid",  cdb_valid_flat,     4'b1111);
      check("six_B_index",  cdb_rob_index_flat, 16'h4567);
      check("six_B_result", cdb_result_flat,    64'h6004_6005_6006_6007);
      tick();
      check("six_C_index",  cdb_rob_index_flat, 16'h89AB);
      check("six_C_result", cdb_result_flat,    64'h6008_6009_600A_600B);
      tick();
      check("six_drained_valid", cdb_valid_flat, 4'b0000);
      check("six_drained_busy",  busy,           1'b0);

      // Back-to-back results from one unit.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_fu(1, 4'(i), 16'hB000 + 16'(i));
         check("b2b_ready1", fu_ready_flat[1], 1'b1);
         tick();
         if (i > 0) begin
            check("b2b_valid",  cdb_valid_flat,         4'b1000);
            check("b2b_result", cdb_result_flat[63:48], 16'hB000 + 16'(i - 1));
         end
      end
      idle();
      tick();
      check("b2b_last", cdb_result_flat[63:48], 16'hB007);
      tick();
      check("b2b_done", cdb_valid_flat, 4'b0000);

      // Flush with a non-zero pointer.
      do_reset();
      set_fu(0, 4'd1, 16'hC001);
      tick();
      idle();
      tick();
      for (int f = 0; f < 3; f++) set_fu(f, 4'(f + 2), 16'hC002 + 16'(f));
      tick();
      idle();
      flush = 1'b1;
      set_fu(3, 4'd12, 16'hC00C);
      tick();
      idle();
      check("flush_valid", cdb_valid_flat, 4'b0000);
      check("flush_busy",  busy,           1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("flush_quiet", cdb_valid_flat, 4'b0000);
      end
      set_fu(0, 4'd5, 16'hC005);
      set_fu(1, 4'd6, 16'hC006);
      tick();
      idle();
      tick();
      check("flush_ptr_valid",  cdb_valid_flat,     4'b1100);
      check("flush_ptr_index",  cdb_rob_index_flat, 16'h6500);
      check("flush_ptr_result", cdb_result_flat,    64'hC006_C005_0000_0000);

      // Asynchronous reset while lanes are valid.
      do_reset();
      for (int f = 0; f < N; f++) set_fu(f, 4'(f), 16'hD000 + 16'(f));
      tick();
      idle();
      tick();
      check("arst_pre_valid", cdb_valid_flat, 4'b1111);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid",  cdb_valid_flat,     4'd0);
      check("arst_index",  cdb_rob_index_flat, 16'd0);
      check("arst_result", cdb_result_flat,    64'd0);
      check("arst_busy",   busy,               1'b0);
      check("arst_ready",  fu_ready_flat,      6'h3F);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("arst_after", cdb_valid_flat, 4'b0000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
